spi_dma_master: RTL and testbench
=================================

// Module: spi_dma_master
// PURPOSE
//  SPI byte-exchange master that sits directly downstream of the DMA engine and the Z80 port decoder.
//  - DMA side: serves spi_req / spi_wrdata, returns spi_rddata plus a one-clock spi_stb per byte.
//  - Z80 side: direct byte exchanges through the SPI data port, plus chip-select and divider control.
//  - SPI mode 0, MSB first. One byte per exchange; the DMA pairs bytes into words on its own.
// PARAMETERS
//  DIV_W    8     width of the SCK half-period divider register
//  DIV_RST  8'd3  divider value loaded at reset (half-period = DIV+1 clk cycles)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      synchronous reset, active low
//  zdata      in   8      Z80 write data
//  z_wr_data  in   1      1-clk strobe: write to SPI data port; starts an exchange sending zdata
//  z_rd_data  in   1      1-clk strobe: read of SPI data port; starts an exchange sending 8'hFF
//  z_wr_ctrl  in   1      1-clk strobe: zdata[0] -> cs_n register
//  z_wr_div   in   1      1-clk strobe: zdata[DIV_W-1:0] -> divider register
//  z_rddata   out  8      last received byte (all exchanges)
//  busy       out  1      exchange in progress or Z80 request pending
//  dma_req    in   1      DMA requests a byte exchange (level)
//  dma_wrdata in   8      byte to send; 8'hFF on DMA read cycles
//  dma_rddata out  8      received byte; valid while dma_stb=1, held afterwards
//  dma_stb    out  1      1-clk pulse: DMA-originated exchange finished
//  spi_sck    out  1      SPI clock, idles low
//  spi_mosi   out  1      SPI data out, idles high
//  spi_miso   in   1      SPI data in, synchronous to clk domain
//  spi_cs_n   out  1      chip select, direct from the control register
// BEHAVIOUR
//  Reset
//  - State IDLE; spi_sck=0, spi_mosi=1, spi_cs_n=1.
//  - dma_stb=0, busy=0, z_rddata=dma_rddata=8'hFF, divider=DIV_RST, pending cleared.
//  - Reset mid-exchange aborts immediately. No dma_stb is issued; the partial byte is discarded.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE
//  - Request sources are a pending Z80 request or dma_req=1. Pending Z80 beats DMA.
//  - In cycle S the source's byte is latched into the shifter and the owner (Z80/DMA) is recorded.
//  - S+1: enter SHIFT with mosi=bit7, sck=0.
//  SHIFT
//  - Divider counter reloads with DIV and counts down; at 0, sck toggles.
//  - Rising edge: sample miso into the shift LSB.
//  - Falling edge: shift left; mosi = next bit.
//  - After 16 toggles (sck back at 0), go to DONE.
//  DONE: exactly 1 clk.
//  - z_rddata is updated with the received byte.
//  - If the owner is DMA: dma_rddata is updated and dma_stb=1. The DMA toggles its byte select on this edge.
//  - Then return to IDLE. dma_req and dma_wrdata are not sampled in DONE, so the next byte picks up the updated select.
//  Timing
//  - dma_stb is high in cycle S+1+16*(DIV+1).
//  - Back-to-back DMA bytes: next S = stb cycle + 1.
//  Z80 strobes
//  - Z80 strobe arriving while busy or in DONE: latched as a one-deep pending request (data byte or FF).
//  - A second strobe while pending overwrites it, last wins.
//  - Z80 strobe in IDLE with dma_req=1: the Z80 is served first.
//  Other boundaries
//  - dma_req dropping mid-exchange: the exchange completes and dma_stb is still pulsed.
//  - z_wr_div mid-exchange: takes effect at the next divider reload.
//  - z_wr_ctrl takes effect next clk regardless of state.
//  - busy = (state!=IDLE) | pending.
// STRUCTURE
//  - Shared package/include: FSM state encodings (2 bit), DIV_RST, SPI_IDLE_MOSI=1'b1, SPI_FILL=8'hFF.
//  - Sub-module spi_sck_div: divider counter + toggle strobe + rise/fall flags. Inputs: enable, div.
//  - Top level holds the FSM, shifter, bit counter (0..15 toggles), pending/owner flags and arbitration.
// TESTING
//  1. DIV=0, dma_req=1, wrdata=8'hA5, miso loopback to mosi -> stb at S+17, dma_rddata=8'hA5, mosi bits 1,0,1,0,0,1,0,1.
//  2. DMA word (req held for two bytes, 8'h12 then 8'h34) -> two stb pulses 18 clk apart (DIV=0); second byte sent is 8'h34.
//  3. z_rd_data while DMA byte in flight -> DMA byte completes with stb, Z80 exchange of 8'hFF follows, busy drops after it, no extra stb.
//  4. DIV=3, Z80 write 8'h3C, miso tied 0 -> sck half-period 4 clk, z_rddata=8'h00 at S+65, dma_stb never asserted.
//  5. rst_n low at toggle 7 of a DMA byte -> next clk: sck=0, mosi=1, cs_n=1, busy=0, no stb; new dma_req is then served normally.
//  6. z_wr_ctrl 0 then 1 -> cs_n follows one clk after each strobe; z_wr_div mid-byte changes the period only from the next reload.

Source files
------------

// File: rtl/spi_dma_master_pkg.sv
// Shared definitions for the SPI byte-exchange master: FSM encoding and
// the constants the datapath drives when idle or filling a read cycle.
package spi_dma_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] SPI_DIV_RST   = 8'd3;
  localparam logic       SPI_IDLE_MOSI = 1'b1;
  localparam logic [7:0] SPI_FILL      = 8'hFF;

endpackage

// File: rtl/spi_dma_master_if.sv
// Host-side bus of the SPI master: Z80 port strobes plus the DMA byte
// handshake. The slave modport is the SPI master itself; the master modport
// is whoever drives the requests.
interface spi_dma_master_if;

  logic [7:0] zdata;
  logic       z_wr_data;
  logic       z_rd_data;
  logic       z_wr_ctrl;
  logic       z_wr_div;
  logic [7:0] z_rddata;
  logic       busy;
  logic       dma_req;
  logic [7:0] dma_wrdata;
  logic [7:0] dma_rddata;
  logic       dma_stb;

  modport slave (
    input  zdata, z_wr_data, z_rd_data, z_wr_ctrl, z_wr_div, dma_req, dma_wrdata,
    output z_rddata, busy, dma_rddata, dma_stb
  );

  modport master (
    output zdata, z_wr_data, z_rd_data, z_wr_ctrl, z_wr_div, dma_req, dma_wrdata,
    input  z_rddata, busy, dma_rddata, dma_stb
  );

endinterface

// File: rtl/spi_dma_master_sck_div.sv
// SCK generator: a down-counter reloaded from the divider register that
// toggles SCK each time it reaches zero. While disabled it holds SCK low and
// keeps reloading, so a new exchange always starts with a full half-period.
module spi_dma_master_sck_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             sck,
  output logic             tick,
  output logic             rise,
  output logic             fall
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);
  assign rise = tick && !sck;
  assign fall = tick && sck;

  // Half-period counter and SCK toggle; a reload picks up the current divider
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= div;
      sck <= 1'b0;
    end else if (cnt == '0) begin
      cnt <= div;
      sck <= ~sck;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_dma_master.sv
// SPI mode-0 byte-exchange master shared by the DMA engine and the Z80.
// A pending Z80 request always wins arbitration over the DMA; every finished
// byte updates z_rddata, and DMA-owned bytes also pulse dma_stb.
module spi_dma_master
  import spi_dma_master_pkg::*;
#(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(SPI_DIV_RST)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_dma_master_if.slave        bus,
  output logic                   spi_sck,
  output logic                   spi_mosi,
  input  logic                   spi_miso,
  output logic                   spi_cs_n
);

  state_t           state, state_nxt;
  logic [7:0]       shreg;
  logic             rx_bit;
  logic [3:0]       tog_cnt;
  logic             owner_dma;
  logic             pend;
  logic [7:0]       pend_byte;
  logic [DIV_W-1:0] div;
  logic             mosi_q;
  logic             cs_q;
  logic [7:0]       z_rd_q;
  logic [7:0]       dma_rd_q;
  logic             z_strobe;
  logic [7:0]       z_byte;
  logic             start;
  logic             start_z;
  logic [7:0]       start_byte;
  logic             last_tog;
  logic             tick, rise, fall;

  assign z_strobe = bus.z_wr_data || bus.z_rd_data;
  assign z_byte   = bus.z_wr_data ? bus.zdata : SPI_FILL;

  spi_dma_master_sck_div #(.DIV_W(DIV_W)) u_sck_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_SHIFT),
    .div   (div),
    .sck   (spi_sck),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Arbitration (fresh Z80 strobe, then pending Z80, then DMA) and next state
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    start_z    = 1'b0;
    start_byte = SPI_FILL;
    last_tog   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (z_strobe) begin
          start      = 1'b1;
          start_z    = 1'b1;
          start_byte = z_byte;
        end else if (pend) begin
          start      = 1'b1;
          start_z    = 1'b1;
          start_byte = pend_byte;
        end else if (bus.dma_req) begin
          start      = 1'b1;
          start_byte = bus.dma_wrdata;
        end
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        last_tog = tick && (tog_cnt == 4'd15);
        if (last_tog) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Shifter: load on start, sample MISO on rising SCK, shift on falling SCK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= SPI_FILL;
      rx_bit    <= 1'b0;
      tog_cnt   <= 4'd0;
      owner_dma <= 1'b0;
      mosi_q    <= SPI_IDLE_MOSI;
      z_rd_q    <= SPI_FILL;
      dma_rd_q  <= SPI_FILL;
    end else if (start) begin
      shreg     <= start_byte;
      owner_dma <= !start_z;
      mosi_q    <= start_byte[7];
      tog_cnt   <= 4'd0;
    end else if (tick) begin
      tog_cnt <= tog_cnt + 4'd1;
      if (rise) rx_bit <= spi_miso;
      if (fall) begin
        shreg  <= {shreg[6:0], rx_bit};
        mosi_q <= last_tog ? SPI_IDLE_MOSI : shreg[6];
      end
      if (last_tog) begin
        z_rd_q <= {shreg[6:0], rx_bit};
        if (owner_dma) dma_rd_q <= {shreg[6:0], rx_bit};
      end
    end
  end

  // One-deep Z80 request buffer for strobes that arrive while not idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_byte <= SPI_FILL;
    end else if (z_strobe && (state != ST_IDLE)) begin
      pend      <= 1'b1;
      pend_byte <= z_byte;
    end else if (start_z) begin
      pend      <= 1'b0;
    end
  end

  // Chip-select and divider registers, written in any state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q <= 1'b1;
      div  <= DIV_RST;
    end else begin
      if (bus.z_wr_ctrl) cs_q <= bus.zdata[0];
      if (bus.z_wr_div)  div  <= bus.zdata[DIV_W-1:0];
    end
  end

  assign spi_mosi       = mosi_q;
  assign spi_cs_n       = cs_q;
  assign bus.z_rddata   = z_rd_q;
  assign bus.dma_rddata = dma_rd_q;
  assign bus.dma_stb    = (state == ST_DONE) && owner_dma;
  assign bus.busy       = (state != ST_IDLE) || pend;

endmodule

// File: tb/tb_spi_dma_master.sv
// Scoreboard bench for spi_dma_master: stimulus pushes expected DMA strobes,
// exchange completions (busy falling) and transmitted bytes; a negedge
// monitor pops and compares them as the DUT produces them.
module tb_spi_dma_master;

  localparam int OP_WR   = 0;
  localparam int OP_RD   = 1;
  localparam int OP_CTRL = 2;
  localparam int OP_DIV  = 3;

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_sck, spi_mosi, spi_miso, spi_cs_n;
  logic loopback = 1'b1;
  logic miso_fix = 1'b0;

  spi_dma_master_if bus();

  spi_dma_master #(.DIV_W(8), .DIV_RST(8'd3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  assign spi_miso = loopback ? spi_mosi : miso_fix;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t       dq[$];
  exp_t       zq[$];
  logic [7:0] txq[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one Z80 port strobe in the current cycle; s returns that cycle
  task automatic apply_stimulus(input int op, input logic [7:0] d, output int s);
    s = cyc;
    bus.zdata = d;
    case (op)
      OP_WR:   bus.z_wr_data = 1'b1;
      OP_RD:   bus.z_rd_data = 1'b1;
      OP_CTRL: bus.z_wr_ctrl = 1'b1;
      default: bus.z_wr_div  = 1'b1;
    endcase
    tick();
    bus.z_wr_data = 1'b0;
    bus.z_rd_data = 1'b0;
    bus.z_wr_ctrl = 1'b0;
    bus.z_wr_div  = 1'b0;
  endtask

  task automatic wait_stb(input int budget);
    int n = 0;
    while (!bus.dma_stb && n < budget) begin
      tick();
      n++;
    end
    if (!bus.dma_stb) begin
      checks++;
      errors++;
      $display("[TB] FAIL dma_stb_timeout: no strobe within %0d cycles", budget);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((dq.size() != 0 || zq.size() != 0 || txq.size() != 0 || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    if (dq.size() != 0 || zq.size() != 0 || txq.size() != 0 || bus.busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: dq=%0d zq=%0d txq=%0d busy=%0b",
               dq.size(), zq.size(), txq.size(), bus.busy);
      dq.delete();
      zq.delete();
      txq.delete();
    end
  endtask

  // Monitor: DMA strobes, exchange completions and MOSI bytes vs. expectations
  logic       prev_busy = 1'b0;
  logic       prev_sck = 1'b0;
  int         bit_cnt = 0;
  logic [7:0] cap = 8'h00;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_sck  = 1'b0;
      bit_cnt   = 0;
    end else begin
      if (bus.dma_stb) begin
        if (dq.size() == 0) begin
          check_output("unexpected_dma_stb", 32'(bus.dma_stb), 32'd0);
        end else begin
          mon_e = dq.pop_front();
          check_output("dma_rddata", 32'(bus.dma_rddata), 32'(mon_e.data));
          check_output("dma_stb_cycle", 32'(cyc), mon_e.cyc);
        end
      end
      if (prev_busy && !bus.busy) begin
        if (zq.size() == 0) begin
          check_output("unexpected_busy_fall", 32'(prev_busy), 32'd0);
        end else begin
          mon_e = zq.pop_front();
          check_output("z_rddata", 32'(bus.z_rddata), 32'(mon_e.data));
          check_output("busy_fall_cycle", 32'(cyc), mon_e.cyc);
        end
      end
      if (spi_sck && !prev_sck) begin
        cap = {cap[6:0], spi_mosi};
        bit_cnt++;
        if (bit_cnt == 8) begin
          bit_cnt = 0;
          if (txq.size() == 0) check_output("unexpected_tx_byte", 32'(txq.size()), 32'd1);
          else                 check_output("mosi_byte", 32'(cap), 32'(txq.pop_front()));
        end
      end
      prev_busy = bus.busy;
      prev_sck  = spi_sck;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, s2;
    bus.zdata      = 8'h00;
    bus.z_wr_data  = 1'b0;
    bus.z_rd_data  = 1'b0;
    bus.z_wr_ctrl  = 1'b0;
    bus.z_wr_div   = 1'b0;
    bus.dma_req    = 1'b0;
    bus.dma_wrdata = 8'hFF;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] reset state");
    check_output("rst_sck", 32'(spi_sck), 32'd0);
    check_output("rst_mosi", 32'(spi_mosi), 32'd1);
    check_output("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_stb", 32'(bus.dma_stb), 32'd0);
    check_output("rst_z_rddata", 32'(bus.z_rddata), 32'hFF);
    check_output("rst_dma_rddata", 32'(bus.dma_rddata), 32'hFF);

    $display("[TB] chip select low, divider 0");
    apply_stimulus(OP_CTRL, 8'h00, s);
    check_output("cs_n_low", 32'(spi_cs_n), 32'd0);
    apply_stimulus(OP_DIV, 8'h00, s);

    $display("[TB] single DMA byte A5 with loopback");
    s = cyc;
    bus.dma_req = 1'b1;
    bus.dma_wrdata = 8'hA5;
    dq.push_back('{data: 8'hA5, cyc: 32'(s + 17)});
    zq.push_back('{data: 8'hA5, cyc: 32'(s + 18)});
    txq.push_back(8'hA5);
    wait_stb(100);
    bus.dma_req = 1'b0;
    drain(200);

    $display("[TB] DMA word 12 34");
    s = cyc;
    bus.dma_req = 1'b1;
    bus.dma_wrdata = 8'h12;
    dq.push_back('{data: 8'h12, cyc: 32'(s + 17)});
    dq.push_back('{data: 8'h34, cyc: 32'(s + 35)});
    zq.push_back('{data: 8'h12, cyc: 32'(s + 18)});
    zq.push_back('{data: 8'h34, cyc: 32'(s + 36)});
    txq.push_back(8'h12);
    txq.push_back(8'h34);
    wait_stb(100);
    bus.dma_wrdata = 8'h34;
    tick();
    wait_stb(100);
    bus.dma_req = 1'b0;
    drain(200);

    $display("[TB] Z80 read queued behind DMA byte");
    s = cyc;
    bus.dma_req = 1'b1;
    bus.dma_wrdata = 8'h5A;
    dq.push_back('{data: 8'h5A, cyc: 32'(s + 17)});
    zq.push_back('{data: 8'hFF, cyc: 32'(s + 36)});
    txq.push_back(8'h5A);
    txq.push_back(8'hFF);
    repeat (5) tick();
    apply_stimulus(OP_RD, 8'h00, s2);
    wait_stb(100);
    bus.dma_req = 1'b0;
    drain(200);

    $display("[TB] Z80 write 3C at divider 3, MISO low");
    loopback = 1'b0;
    miso_fix = 1'b0;
    apply_stimulus(OP_DIV, 8'h03, s);
    apply_stimulus(OP_WR, 8'h3C, s);
    zq.push_back('{data: 8'h00, cyc: 32'(s + 66)});
    txq.push_back(8'h3C);
    s2 = 0;
    while (!spi_sck && s2 < 50) begin
      tick();
      s2++;
    end
    check_output("first_sck_rise_cycle", 32'(cyc), 32'(s + 5));
    drain(300);

    $display("[TB] divider change mid-byte");
    loopback = 1'b1;
    apply_stimulus(OP_WR, 8'h81, s);
    tick();
    apply_stimulus(OP_DIV, 8'h00, s2);
    zq.push_back('{data: 8'h81, cyc: 32'(s + 21)});
    txq.push_back(8'h81);
    drain(300);

    $display("[TB] chip select control");
    apply_stimulus(OP_CTRL, 8'h01, s);
    check_output("cs_n_high", 32'(spi_cs_n), 32'd1);
    apply_stimulus(OP_CTRL, 8'h00, s);
    check_output("cs_n_low_again", 32'(spi_cs_n), 32'd0);

    $display("[TB] reset during DMA byte");
    s = cyc;
    bus.dma_req = 1'b1;
    bus.dma_wrdata = 8'h96;
    repeat (7) tick();
    rst_n = 1'b0;
    bus.dma_req = 1'b0;
    tick();
    check_output("abort_sck", 32'(spi_sck), 32'd0);
    check_output("abort_mosi", 32'(spi_mosi), 32'd1);
    check_output("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check_output("abort_busy", 32'(bus.busy), 32'd0);
    check_output("abort_stb", 32'(bus.dma_stb), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] DMA byte after reset uses reset divider");
    s = cyc;
    bus.dma_req = 1'b1;
    bus.dma_wrdata = 8'hC3;
    dq.push_back('{data: 8'hC3, cyc: 32'(s + 65)});
    zq.push_back('{data: 8'hC3, cyc: 32'(s + 66)});
    txq.push_back(8'hC3);
    wait_stb(200);
    bus.dma_req = 1'b0;
    drain(300);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
